// File: rtl/collision_score.sv
// rtl/collision_score.sv - bird vs pipe/coin collision check, BCD scoring and game-over handshake
// Two-stage check per frame tick, level Stop to the tracker until Ack, best score kept across games.
module collision_score #(
    parameter int BIRD_X_L = 200,
    parameter int BIRD_X_R = 220,
    parameter int BIRD_H   = 20,
    parameter int FLOOR_Y  = 460
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        Start,
    input  logic        Ack,
    input  logic        tick,
    input  logic [9:0]  bird_y,
    input  logic [9:0]  pipe_l,
    input  logic [9:0]  pipe_r,
    input  logic [9:0]  gap_top,
    input  logic [9:0]  gap_bot,
    input  logic [2:0]  pipe_idx,
    input  logic [9:0]  coin_l,
    input  logic [9:0]  coin_r,
    input  logic [9:0]  coin_y,
    input  logic [2:0]  coin_idx,
    output logic        Stop,
    output logic        hit,
    output logic        coin_taken,
    output logic [11:0] score,
    output logic [7:0]  coins,
    output logic [11:0] best,
    output logic        Q_Idle,
    output logic        Q_Run,
    output logic        Q_Done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [9:0]  XL     = 10'(BIRD_X_L);
    localparam logic [9:0]  XR     = 10'(BIRD_X_R);
    localparam logic [10:0] BH     = 11'(BIRD_H);
    localparam logic [10:0] FY     = 11'(FLOOR_Y);
    localparam logic [10:0] COIN_H = 11'd20;

    logic [1:0]  state;
    logic        tick_d;
    logic        px_ovl;
    logic        py_bad;
    logic        floor_hit;
    logic        c_ovl;
    logic [2:0]  prev_pipe_idx;
    logic [2:0]  prev_coin_idx;

    // BCD +1 that sticks at 999
    function automatic logic [11:0] bcd_inc(input logic [11:0] v);
        logic [11:0] r;
        r = v;
        if (v != 12'h999) begin
            if (v[3:0] != 4'd9) begin
                r[3:0] = v[3:0] + 4'd1;
            end else begin
                r[3:0] = 4'd0;
                if (v[7:4] != 4'd9) begin
                    r[7:4] = v[7:4] + 4'd1;
                end else begin
                    r[7:4]  = 4'd0;
                    r[11:8] = v[11:8] + 4'd1;
                end
            end
        end
        return r;
    endfunction

    // Y arithmetic is one bit wider so a bird near row 1023 cannot wrap
    logic [10:0] bird_top;
    logic [10:0] bird_bot;
    logic        s1_px;
    logic        s1_py;
    logic        s1_floor;
    logic        s1_coin;
    logic        collide;
    logic        pipe_step;
    logic [11:0] score_next;

    assign bird_top = {1'b0, bird_y};
    assign bird_bot = bird_top + BH;

    assign s1_px    = (pipe_l < XR) && (pipe_r > XL);
    assign s1_py    = (bird_top < {1'b0, gap_top}) || (bird_bot > {1'b0, gap_bot});
    assign s1_floor = (bird_bot >= FY);
    assign s1_coin  = (coin_l < XR) && (coin_r > XL) &&
                      (bird_top < ({1'b0, coin_y} + COIN_H)) &&
                      (bird_bot > {1'b0, coin_y});

    assign collide    = tick_d && ((px_ovl && py_bad) || floor_hit);
    assign pipe_step  = (pipe_idx != prev_pipe_idx);
    assign score_next = pipe_step ? bcd_inc(score) : score;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            tick_d        <= 1'b0;
            px_ovl        <= 1'b0;
            py_bad        <= 1'b0;
            floor_hit     <= 1'b0;
            c_ovl         <= 1'b0;
            prev_pipe_idx <= 3'd0;
            prev_coin_idx <= 3'd0;
            hit           <= 1'b0;
            coin_taken    <= 1'b0;
            score         <= 12'h000;
            coins         <= 8'd0;
            best          <= 12'h000;
        end else begin
            hit <= 1'b0;
            case (state)
                S_IDLE: begin
                    tick_d        <= 1'b0;
                    px_ovl        <= 1'b0;
                    py_bad        <= 1'b0;
                    floor_hit     <= 1'b0;
                    c_ovl         <= 1'b0;
                    score         <= 12'h000;
                    coins         <= 8'd0;
                    coin_taken    <= 1'b0;
                    prev_pipe_idx <= pipe_idx;
                    prev_coin_idx <= coin_idx;
                    if (Start) begin
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    tick_d <= tick;
                    if (tick) begin
                        px_ovl    <= s1_px;
                        py_bad    <= s1_py;
                        floor_hit <= s1_floor;
                        c_ovl     <= s1_coin;
                    end
                    prev_pipe_idx <= pipe_idx;
                    prev_coin_idx <= coin_idx;
                    score         <= score_next;
                    // a new coin arriving on the collect cycle is never credited
                    if (coin_idx != prev_coin_idx) begin
                        coin_taken <= 1'b0;
                    end else if (tick_d && c_ovl && !coin_taken) begin
                        coin_taken <= 1'b1;
                        if (coins != 8'hFF) begin
                            coins <= coins + 8'd1;
                        end
                    end
                    if (collide) begin
                        hit   <= 1'b1;
                        state <= S_DONE;
                        if (score_next > best) begin
                            best <= score_next;
                        end
                    end
                end
                S_DONE: begin
                    tick_d <= 1'b0;
                    if (Ack) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    tick_d <= 1'b0;
                end
            endcase
        end
    end

    assign Stop   = (state == S_DONE);
    assign Q_Idle = (state == S_IDLE);
    assign Q_Run  = (state == S_RUN);
    assign Q_Done = (state == S_DONE);

endmodule

// File: tb/tb_collision_score.sv
// tb/tb_collision_score.sv - scoreboard bench for collision_score with a game-level reference model
module tb_collision_score;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        Start, Ack, tick;
    logic [9:0]  bird_y, pipe_l, pipe_r, gap_top, gap_bot;
    logic [2:0]  pipe_idx, coin_idx;
    logic [9:0]  coin_l, coin_r, coin_y;
    logic        Stop, hit, coin_taken;
    logic [11:0] score, best;
    logic [7:0]  coins;
    logic        Q_Idle, Q_Run, Q_Done;

    collision_score dut (
        .clk(clk), .reset_n(reset_n), .Start(Start), .Ack(Ack), .tick(tick),
        .bird_y(bird_y), .pipe_l(pipe_l), .pipe_r(pipe_r), .gap_top(gap_top), .gap_bot(gap_bot),
        .pipe_idx(pipe_idx), .coin_l(coin_l), .coin_r(coin_r), .coin_y(coin_y), .coin_idx(coin_idx),
        .Stop(Stop), .hit(hit), .coin_taken(coin_taken), .score(score), .coins(coins), .best(best),
        .Q_Idle(Q_Idle), .Q_Run(Q_Run), .Q_Done(Q_Done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        stop;
        logic        hit;
        logic        taken;
        logic [11:0] score;
        logic [7:0]  coins;
        logic [11:0] best;
        logic        qi;
        logic        qr;
        logic        qd;
    } snap_t;

    typedef struct {
        int due;
        bit collide;
        bit coin;
    } verdict_t;

    snap_t    exp_q[$];
    verdict_t vq[$];
    int       n_checks = 0;
    int       n_fail = 0;
    int       cyc = 0;

    // game-level model: 0 idle, 1 playing, 2 game over; score kept as a plain integer
    int phase, m_score, m_coins, m_best, m_prev_pipe, m_prev_coin;
    bit m_taken;

    function automatic logic [11:0] to_bcd(input int v);
        return 12'(((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10));
    endfunction

    task automatic model_step();
        bit m_hit, vc, vk, c, k;
        int by;
        m_hit = 0; vc = 0; vk = 0;
        by = int'(bird_y);
        if (!reset_n) begin
            phase = 0; m_score = 0; m_coins = 0; m_best = 0; m_taken = 0;
            m_prev_pipe = 0; m_prev_coin = 0;
            vq.delete();
        end else if (phase == 0) begin
            m_score = 0; m_coins = 0; m_taken = 0;
            m_prev_pipe = int'(pipe_idx); m_prev_coin = int'(coin_idx);
            vq.delete();
            if (Start) phase = 1;
        end else if (phase == 1) begin
            if (vq.size() > 0 && vq[0].due == cyc) begin
                vc = vq[0].collide; vk = vq[0].coin;
                void'(vq.pop_front());
            end
            if (int'(pipe_idx) != m_prev_pipe && m_score < 999) m_score++;
            if (int'(coin_idx) != m_prev_coin) m_taken = 0;
            else if (vk && !m_taken) begin
                m_taken = 1;
                if (m_coins < 255) m_coins++;
            end
            if (tick) begin
                c = ((int'(pipe_l) < 220) && (int'(pipe_r) > 200) &&
                     ((by < int'(gap_top)) || (by + 20 > int'(gap_bot)))) || (by + 20 >= 460);
                k = (int'(coin_l) < 220) && (int'(coin_r) > 200) &&
                    (by < int'(coin_y) + 20) && (by + 20 > int'(coin_y));
                vq.push_back('{due: cyc + 1, collide: c, coin: k});
            end
            m_prev_pipe = int'(pipe_idx); m_prev_coin = int'(coin_idx);
            if (vc) begin
                m_hit = 1;
                phase = 2;
                if (m_score > m_best) m_best = m_score;
            end
        end else begin
            vq.delete();
            if (Ack) phase = 0;
        end
        exp_q.push_back('{stop: (phase == 2), hit: m_hit, taken: m_taken, score: to_bcd(m_score),
                          coins: 8'(m_coins), best: to_bcd(m_best),
                          qi: (phase == 0), qr: (phase == 1), qd: (phase == 2)});
        cyc++;
    endtask

    // monitor: every registered output sample is matched against the next expected snapshot
    initial begin
        snap_t a, e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {Stop, hit, coin_taken, score, coins, best, Q_Idle, Q_Run, Q_Done};
                n_checks++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL snapshot t=%0t got stop=%b hit=%b taken=%b score=%h coins=%0d best=%h q=%b%b%b required stop=%b hit=%b taken=%b score=%h coins=%0d best=%h q=%b%b%b",
                             $time, a.stop, a.hit, a.taken, a.score, a.coins, a.best, a.qi, a.qr, a.qd,
                             e.stop, e.hit, e.taken, e.score, e.coins, e.best, e.qi, e.qr, e.qd);
                end
            end
        end
    end

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s got %h required %h", name, act, req);
        end
    endtask

    task automatic step();
        model_step();
        @(negedge clk);
    endtask

    task automatic step_n(input int n);
        repeat (n) step();
    endtask

    task automatic set_safe();
        tick = 0; Start = 0; Ack = 0;
        bird_y = 200; pipe_l = 400; pipe_r = 440; gap_top = 150; gap_bot = 250;
        coin_l = 600; coin_r = 620; coin_y = 0;
    endtask

    task automatic start_game();
        Start = 1; step(); Start = 0; step();
    endtask

    task automatic pulse_tick();
        tick = 1; step(); tick = 0; step_n(2);
    endtask

    task automatic advance_pipes(input int n);
        repeat (n) begin
            pipe_idx = pipe_idx + 3'd1;
            step();
        end
    endtask

    task automatic end_game();
        bird_y = 445;
        pulse_tick();
        step();
        Ack = 1; step(); Ack = 0; bird_y = 200; step();
    endtask

    task automatic reset_pulse();
        reset_n = 0; step(); reset_n = 1; step();
    endtask

    initial begin
        reset_n = 0; pipe_idx = 0; coin_idx = 0;
        set_safe();
        @(negedge clk);
        step();
        check("reset_q_idle", {11'd0, Q_Idle}, 12'h001);
        check("reset_stop", {11'd0, Stop}, 12'h000);
        reset_n = 1;
        step();

        // pipe overlap, bird inside gap then above it
        start_game();
        pipe_l = 180; pipe_r = 340;
        pulse_tick();
        check("in_gap_stop", {11'd0, Stop}, 12'h000);
        bird_y = 100;
        pulse_tick();
        check("above_gap_stop", {11'd0, Stop}, 12'h001);
        Ack = 1; step(); Ack = 0; step();

        // floor hit with a long wait for Ack
        set_safe();
        start_game();
        bird_y = 445;
        pulse_tick();
        step_n(10);
        check("floor_stop_held", {11'd0, Stop}, 12'h001);
        Ack = 1; step(); Ack = 0; step();
        check("after_ack_idle", {11'd0, Q_Idle}, 12'h001);
        bird_y = 200;

        // score stepping including an index wrap
        pipe_idx = 2; step();
        start_game();
        pipe_idx = 3; step();
        pipe_idx = 4; step();
        pipe_idx = 0; step();
        check("score_three", score, 12'h003);
        end_game();

        // coin collection and release on the next coin
        start_game();
        coin_l = 205; coin_r = 225; coin_y = 200;
        repeat (3) pulse_tick();
        check("coins_one", {4'd0, coins}, 12'h001);
        check("coin_taken_set", {11'd0, coin_taken}, 12'h001);
        coin_idx = coin_idx + 3'd1; step();
        check("coin_taken_clear", {11'd0, coin_taken}, 12'h000);
        set_safe();
        end_game();

        // best score across games
        reset_pulse();
        start_game(); advance_pipes(12); end_game();
        check("best_12", best, 12'h012);
        start_game(); advance_pipes(7); end_game();
        check("best_still_12", best, 12'h012);
        start_game(); advance_pipes(15); end_game();
        check("best_15", best, 12'h015);

        // score saturation
        start_game(); advance_pipes(1003);
        check("score_sat", score, 12'h999);
        end_game();
        check("best_sat", best, 12'h999);

        // asynchronous reset mid-game
        start_game(); advance_pipes(5);
        check("score_five", score, 12'h005);
        reset_n = 0;
        #1;
        check("async_score", score, 12'h000);
        check("async_best", best, 12'h000);
        check("async_state", {9'd0, Q_Idle, Q_Run, Q_Done}, 12'h004);
        step();
        reset_n = 1;
        step();

        // randomized play
        for (int i = 0; i < 4000; i++) begin
            tick  = ($urandom_range(0, 3) == 0);
            Start = ($urandom_range(0, 9) == 0);
            Ack   = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 15))
                0:       bird_y = 10'($urandom_range(0, 1023));
                1:       bird_y = 10'($urandom_range(0, 470));
                default: bird_y = 10'($urandom_range(150, 230));
            endcase
            pipe_l = 10'($urandom_range(100, 400));
            pipe_r = pipe_l + 10'($urandom_range(20, 160));
            if ($urandom_range(0, 7) == 0) begin
                gap_top = 10'($urandom_range(80, 200));
                gap_bot = gap_top + 10'($urandom_range(60, 140));
            end else begin
                gap_top = 150; gap_bot = 250;
            end
            coin_l = 10'($urandom_range(150, 260));
            coin_r = coin_l + 10'd20;
            coin_y = 10'($urandom_range(100, 300));
            if ($urandom_range(0, 5) == 0) pipe_idx = pipe_idx + 3'd1;
            if ($urandom_range(0, 7) == 0) coin_idx = coin_idx + 3'd1;
            step();
        end

        set_safe();
        step_n(2);
        @(posedge clk);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
